// File: rtl/f2f_pkg.sv
// Shared types and helpers for the f2f half-duplex link controller.
package f2f_pkg;

    typedef enum logic [2:0] {
        IDLE_RST,
        OWN,
        HANDOVER,
        LISTEN,
        TURN
    } link_state_e;

    localparam int MAX_LANES = 32;
    localparam int STAT_W    = 32;

    // Payload width: every lane except the top (control) lane carries data.
    function automatic int payload_width(input int lanes);
        return lanes - 1;
    endfunction

    // Handover token: control lane low, all data lanes high.
    function automatic logic [MAX_LANES-1:0] handover_word(input int lanes);
        return (MAX_LANES'(1) << (lanes - 1)) - MAX_LANES'(1);
    endfunction

endpackage

// File: rtl/f2f_link_stats.sv
// Wrapping event counters for f2f_hdx_link; compiled only when F2F_LINK_STATS_EN is defined.
`ifdef F2F_LINK_STATS_EN
module f2f_link_stats
    import f2f_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_ev_i,
    input  logic              rx_ev_i,
    input  logic              hdo_ev_i,
    input  logic              err_ev_i,
    output logic [STAT_W-1:0] tx_cnt_o,
    output logic [STAT_W-1:0] rx_cnt_o,
    output logic [STAT_W-1:0] hdo_cnt_o,
    output logic [STAT_W-1:0] err_cnt_o
);

    logic [STAT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [STAT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [STAT_W-1:0] hdo_cnt_q, hdo_cnt_d;
    logic [STAT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        tx_cnt_d  = tx_cnt_q  + STAT_W'(tx_ev_i);
        rx_cnt_d  = rx_cnt_q  + STAT_W'(rx_ev_i);
        hdo_cnt_d = hdo_cnt_q + STAT_W'(hdo_ev_i);
        err_cnt_d = err_cnt_q + STAT_W'(err_ev_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            hdo_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            hdo_cnt_q <= hdo_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tx_cnt_o  = tx_cnt_q;
    assign rx_cnt_o  = rx_cnt_q;
    assign hdo_cnt_o = hdo_cnt_q;
    assign err_cnt_o = err_cnt_q;

endmodule
`endif

// File: rtl/f2f_hdx_link.sv
// Half-duplex token-passing controller for a shared bidirectional BLVDS lane bus.
// Define F2F_LINK_STATS_EN to add the TX/RX/handover/error statistics counters.
module f2f_hdx_link
    import f2f_pkg::*;
#(
    parameter int LANES       = 5,
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 2,
    parameter int TIMEOUT     = 256,
    parameter bit INIT_OWNER  = 1'b0
) (
    input  logic                            CLK_I,
    input  logic                            RST_I,
    input  logic [payload_width(LANES)-1:0] TX_DATA,
    input  logic                            TX_VALID,
    output logic                            TX_READY,
    output logic [payload_width(LANES)-1:0] RX_DATA,
    output logic                            RX_VALID,
    output logic                            OWNER,
    output logic                            LINK_ERR,
    output logic [LANES-1:0]                PAD_DO,
    input  logic [LANES-1:0]                PAD_DI,
    output logic                            PAD_T
`ifdef F2F_LINK_STATS_EN
    ,
    output logic [STAT_W-1:0]               TX_CNT,
    output logic [STAT_W-1:0]               RX_CNT,
    output logic [STAT_W-1:0]               HANDOVER_CNT,
    output logic [STAT_W-1:0]               ERR_CNT
`endif
);

    localparam int D  = payload_width(LANES);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(TURN_CYCLES + 1);

    localparam logic [BW-1:0]    BURST_MAX = BW'(MAX_BURST);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]    TURN_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [LANES-1:0] HDO_WORD  = LANES'(handover_word(LANES));

    link_state_e      state_q, state_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CW-1:0]    turn_q, turn_d;
    logic [LANES-1:0] pad_do_q, pad_do_d;
    logic             pad_t_q, pad_t_d;
    logic             owner_q, owner_d;
    logic             link_err_q, link_err_d;
    logic [LANES-1:0] di_q, di_d;
    logic             di_ok_q, di_ok_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_hdo_q, rx_hdo_d;
    logic [D-1:0]     rx_data_q, rx_data_d;

    logic tx_ready;
    logic is_data, is_hdo;
    logic ev_tx, ev_hdo, ev_err;

    assign tx_ready = (state_q == OWN) && (burst_q < BURST_MAX);

    // A word sampled while our own drivers were enabled is our echo, never the far end.
    always_comb begin
        di_d       = PAD_DI;
        di_ok_d    = pad_t_q;
        is_data    = (state_q == LISTEN) && di_ok_q && di_q[LANES-1];
        is_hdo     = (state_q == LISTEN) && di_ok_q && (di_q == HDO_WORD);
        rx_valid_d = is_data;
        rx_hdo_d   = is_hdo;
        rx_data_d  = is_data ? di_q[D-1:0] : rx_data_q;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        tmo_d      = tmo_q;
        turn_d     = turn_q;
        pad_do_d   = pad_do_q;
        pad_t_d    = pad_t_q;
        owner_d    = owner_q;
        link_err_d = link_err_q;
        ev_tx      = 1'b0;
        ev_hdo     = 1'b0;
        ev_err     = 1'b0;

        case (state_q)
            IDLE_RST: begin
                state_d = INIT_OWNER ? OWN : LISTEN;
                owner_d = INIT_OWNER;
            end
            OWN: begin
                pad_t_d = 1'b0;
                if (TX_VALID && tx_ready) begin
                    pad_do_d = {1'b1, TX_DATA};
                    burst_d  = burst_q + 1'b1;
                    ev_tx    = 1'b1;
                end else begin
                    pad_do_d = HDO_WORD;
                    state_d  = HANDOVER;
                    ev_hdo   = 1'b1;
                end
            end
            HANDOVER: begin
                pad_t_d  = 1'b1;
                pad_do_d = '0;
                burst_d  = '0;
                tmo_d    = '0;
                owner_d  = 1'b0;
                state_d  = LISTEN;
            end
            LISTEN: begin
                // A handover or data word outranks a timeout expiring on the same cycle.
                if (rx_hdo_q) begin
                    state_d = TURN;
                    turn_d  = '0;
                    tmo_d   = '0;
                    ev_hdo  = 1'b1;
                end else if (rx_valid_q) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    link_err_d = 1'b1;
                    ev_err     = 1'b1;
                    tmo_d      = '0;
                    if (INIT_OWNER) begin
                        state_d = TURN;
                        turn_d  = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = OWN;
                    owner_d = 1'b1;
                    turn_d  = '0;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: state_d = IDLE_RST;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= IDLE_RST;
            burst_q    <= '0;
            tmo_q      <= '0;
            turn_q     <= '0;
            pad_do_q   <= '0;
            pad_t_q    <= 1'b1;
            owner_q    <= 1'b0;
            link_err_q <= 1'b0;
            di_q       <= '0;
            di_ok_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_hdo_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            tmo_q      <= tmo_d;
            turn_q     <= turn_d;
            pad_do_q   <= pad_do_d;
            pad_t_q    <= pad_t_d;
            owner_q    <= owner_d;
            link_err_q <= link_err_d;
            di_q       <= di_d;
            di_ok_q    <= di_ok_d;
            rx_valid_q <= rx_valid_d;
            rx_hdo_q   <= rx_hdo_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign TX_READY = tx_ready;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign OWNER    = owner_q;
    assign LINK_ERR = link_err_q;
    assign PAD_DO   = pad_do_q;
    assign PAD_T    = pad_t_q;

`ifdef F2F_LINK_STATS_EN
    f2f_link_stats u_stats (
        .clk_i     (CLK_I),
        .rst_i     (RST_I),
        .tx_ev_i   (ev_tx),
        .rx_ev_i   (rx_valid_q),
        .hdo_ev_i  (ev_hdo),
        .err_ev_i  (ev_err),
        .tx_cnt_o  (TX_CNT),
        .rx_cnt_o  (RX_CNT),
        .hdo_cnt_o (HANDOVER_CNT),
        .err_cnt_o (ERR_CNT)
    );
`else
    logic unused_ev;
    assign unused_ev = ev_tx ^ ev_hdo ^ ev_err;
`endif

endmodule

// File: tb/tb_f2f_hdx_link.sv
// Directed bench: two f2f_hdx_link ends (A starts as owner) joined by a tri-state bus model.
module tb_f2f_hdx_link;

    localparam int LANES = 5;
    localparam int D     = LANES - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_a, rst_b, b_conn;
    logic [D-1:0]     a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic             a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready;
    logic             a_rx_valid, b_rx_valid, a_owner, b_owner, a_link_err, b_link_err;
    logic [LANES-1:0] a_pad_do, b_pad_do, a_di, b_di;
    logic             a_pad_t, b_pad_t;
`ifdef F2F_LINK_STATS_EN
    logic [31:0] a_tx_cnt, a_rx_cnt, a_hdo_cnt, a_err_cnt;
    logic [31:0] b_tx_cnt, b_rx_cnt, b_hdo_cnt, b_err_cnt;
`endif

    // Bus model: each end sees its own drive, else the other end's, else all zeros.
    always_comb begin
        a_di = '0;
        b_di = '0;
        if (!a_pad_t) a_di = a_pad_do;
        else if (b_conn && !b_pad_t) a_di = b_pad_do;
        if (!b_pad_t) b_di = b_pad_do;
        else if (b_conn && !a_pad_t) b_di = a_pad_do;
    end

    f2f_hdx_link #(.LANES(LANES), .MAX_BURST(4), .TURN_CYCLES(2), .TIMEOUT(64), .INIT_OWNER(1'b1)) u_a (
        .CLK_I(clk), .RST_I(rst_a), .TX_DATA(a_tx_data), .TX_VALID(a_tx_valid), .TX_READY(a_tx_ready),
        .RX_DATA(a_rx_data), .RX_VALID(a_rx_valid), .OWNER(a_owner), .LINK_ERR(a_link_err),
        .PAD_DO(a_pad_do), .PAD_DI(a_di), .PAD_T(a_pad_t)
`ifdef F2F_LINK_STATS_EN
        , .TX_CNT(a_tx_cnt), .RX_CNT(a_rx_cnt), .HANDOVER_CNT(a_hdo_cnt), .ERR_CNT(a_err_cnt)
`endif
    );

    f2f_hdx_link #(.LANES(LANES), .MAX_BURST(4), .TURN_CYCLES(2), .TIMEOUT(64), .INIT_OWNER(1'b0)) u_b (
        .CLK_I(clk), .RST_I(rst_b), .TX_DATA(b_tx_data), .TX_VALID(b_tx_valid), .TX_READY(b_tx_ready),
        .RX_DATA(b_rx_data), .RX_VALID(b_rx_valid), .OWNER(b_owner), .LINK_ERR(b_link_err),
        .PAD_DO(b_pad_do), .PAD_DI(b_di), .PAD_T(b_pad_t)
`ifdef F2F_LINK_STATS_EN
        , .TX_CNT(b_tx_cnt), .RX_CNT(b_rx_cnt), .HANDOVER_CNT(b_hdo_cnt), .ERR_CNT(b_err_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int contention = 0;

    always @(negedge clk) begin
        if (b_conn && !a_pad_t && !b_pad_t) contention++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_tx_valid = 1'b0;
        b_tx_valid = 1'b0;
        a_tx_data = '0;
        b_tx_data = '0;
        tick(2);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0]     rxq[$];
        logic [LANES-1:0] logq[$];
        logic [LANES-1:0] exp_log[8];
        int               idx;
        logic             acc;

        b_conn = 1'b1;

        // Reset values, then token ping-pong with no traffic.
        rst_a = 1'b1; rst_b = 1'b1;
        a_tx_valid = 1'b0; b_tx_valid = 1'b0; a_tx_data = '0; b_tx_data = '0;
        tick(2);
        check("rst_a_pad_t", 32'(a_pad_t), 32'h1);
        check("rst_a_pad_do", 32'(a_pad_do), 32'h0);
        check("rst_a_tx_ready", 32'(a_tx_ready), 32'h0);
        check("rst_a_rx_valid", 32'(a_rx_valid), 32'h0);
        check("rst_a_rx_data", 32'(a_rx_data), 32'h0);
        check("rst_a_owner", 32'(a_owner), 32'h0);
        check("rst_a_link_err", 32'(a_link_err), 32'h0);
        check("rst_b_pad_t", 32'(b_pad_t), 32'h1);
        check("rst_b_owner", 32'(b_owner), 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick(1);
        check("pp_a_owner_r1", 32'(a_owner), 32'h1);
        check("pp_a_ready_r1", 32'(a_tx_ready), 32'h1);
        check("pp_b_ready_r1", 32'(b_tx_ready), 32'h0);
        tick(1);
        check("pp_a_hdo_t", 32'(a_pad_t), 32'h0);
        check("pp_a_hdo_do", 32'(a_pad_do), 32'h0F);
        tick(4);
        check("pp_b_owner_h4", 32'(b_owner), 32'h0);
        tick(1);
        check("pp_b_owner_h5", 32'(b_owner), 32'h1);
        tick(1);
        check("pp_b_hdo_do", 32'(b_pad_do), 32'h0F);
        tick(4);
        check("pp_a_owner_h4", 32'(a_owner), 32'h0);
        tick(1);
        check("pp_a_owner_h5", 32'(a_owner), 32'h1);
        tick(40);
        check("pp_contention", 32'(contention), 32'h0);
        check("pp_a_link_err", 32'(a_link_err), 32'h0);
        check("pp_b_link_err", 32'(b_link_err), 32'h0);

        // RX latency: A puts 0xA on the pads at edge n, B reports it after edge n+2.
        reset_all();
        a_tx_valid = 1'b1; a_tx_data = 4'hA;
        tick(2);
        check("lat_a_pad_do", 32'(a_pad_do), 32'h1A);
        check("lat_a_pad_t", 32'(a_pad_t), 32'h0);
        a_tx_valid = 1'b0;
        tick(1);
        check("lat_b_rx_valid_n1", 32'(b_rx_valid), 32'h0);
        check("lat_a_hdo", 32'(a_pad_do), 32'h0F);
        tick(1);
        check("lat_b_rx_valid_n2", 32'(b_rx_valid), 32'h1);
        check("lat_b_rx_data_n2", 32'(b_rx_data), 32'hA);
        tick(1);
        check("lat_b_rx_pulse", 32'(b_rx_valid), 32'h0);

        // Burst limit: six words split 4 + handover + 2 + handover, order preserved.
        reset_all();
        idx = 0;
        for (int cyc = 0; cyc < 200 && !(rxq.size() >= 6 && logq.size() >= 8); cyc++) begin
            a_tx_valid = (idx < 6);
            a_tx_data  = D'(idx + 1);
            acc = a_tx_valid && a_tx_ready;
            tick(1);
            if (acc) idx++;
            if (b_rx_valid) rxq.push_back(b_rx_data);
            if (!a_pad_t && logq.size() < 8) logq.push_back(a_pad_do);
        end
        a_tx_valid = 1'b0;
        exp_log = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h0F, 5'h15, 5'h16, 5'h0F};
        check("burst_rx_count", 32'(rxq.size()), 32'd6);
        check("burst_pad_count", 32'(logq.size()), 32'd8);
        for (int i = 0; i < rxq.size(); i++) check($sformatf("burst_rx_%0d", i), 32'(rxq[i]), 32'(i + 1));
        for (int i = 0; i < logq.size(); i++) check($sformatf("burst_pad_%0d", i), 32'(logq[i]), 32'(exp_log[i]));

        // B disconnected: A times out after 64 LISTEN cycles and reclaims the bus.
        b_conn = 1'b0;
        reset_all();
        tick(66);
        check("tmo_a_err_before", 32'(a_link_err), 32'h0);
        tick(1);
        check("tmo_a_err_set", 32'(a_link_err), 32'h1);
        tick(1);
        check("tmo_a_owner_t1", 32'(a_owner), 32'h0);
        tick(1);
        check("tmo_a_owner_t2", 32'(a_owner), 32'h1);
        check("tmo_b_err", 32'(b_link_err), 32'h1);
        check("tmo_b_owner", 32'(b_owner), 32'h0);
        tick(10);
        check("tmo_a_err_sticky", 32'(a_link_err), 32'h1);
        b_conn = 1'b1;

        // Reset pulse on A mid-burst: pads released immediately, A restarts as owner.
        reset_all();
        a_tx_valid = 1'b1; a_tx_data = 4'h3;
        tick(3);
        check("rb_a_driving", 32'(a_pad_t), 32'h0);
        rst_a = 1'b1;
        tick(1);
        check("rb_a_pad_t", 32'(a_pad_t), 32'h1);
        check("rb_a_pad_do", 32'(a_pad_do), 32'h0);
        check("rb_a_tx_ready", 32'(a_tx_ready), 32'h0);
        check("rb_a_owner", 32'(a_owner), 32'h0);
        check("rb_a_rx_valid", 32'(a_rx_valid), 32'h0);
        check("rb_a_link_err", 32'(a_link_err), 32'h0);
        tick(76);
        check("rb_b_err", 32'(b_link_err), 32'h1);
        rst_a = 1'b0;
        tick(1);
        check("rb_a_owner_again", 32'(a_owner), 32'h1);
        check("rb_a_ready_again", 32'(a_tx_ready), 32'h1);
        tick(1);
        check("rb_a_first_word", 32'(a_pad_do), 32'h13);
        check("rb_a_first_t", 32'(a_pad_t), 32'h0);
        a_tx_valid = 1'b0;
        tick(20);

`ifdef F2F_LINK_STATS_EN
        // Statistics: ten words A -> B, no faults.
        reset_all();
        idx = 0;
        for (int cyc = 0; cyc < 300 && idx < 10; cyc++) begin
            a_tx_valid = 1'b1;
            a_tx_data  = D'(idx + 3);
            acc = a_tx_ready;
            tick(1);
            if (acc) idx++;
        end
        a_tx_valid = 1'b0;
        tick(30);
        check("st_a_tx_cnt", a_tx_cnt, 32'd10);
        check("st_b_rx_cnt", b_rx_cnt, 32'd10);
        check("st_b_tx_cnt", b_tx_cnt, 32'd0);
        check("st_a_err_cnt", a_err_cnt, 32'd0);
        check("st_b_err_cnt", b_err_cnt, 32'd0);
`endif

        check("final_contention", 32'(contention), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
